// File: rtl/operand_pair_serializer.sv
// Operand-pair serializer: captures WIDTH-bit A/B pairs and emits them LSB-first, one bit pair per cycle.
// Define OPERAND_PAIR_SERIALIZER_STALL_EN to add the ser_rdy back-pressure input.
module operand_pair_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_vld,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_last,
`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
  input  logic             ser_rdy,
`endif
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             advance;
  logic             accept;

`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
  assign advance = ser_rdy;
`else
  assign advance = 1'b1;
`endif

  assign ser_vld  = (state_q == SHIFT);
  assign busy     = ser_vld;
  assign ser_a    = sh_a_q[0];
  assign ser_b    = sh_b_q[0];
  assign ser_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign in_rdy   = (state_q == IDLE) || (ser_last && advance);
  assign accept   = in_vld && in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load on the last bit overrides the return to IDLE, giving bubble-free back-to-back words.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    if ((state_q == SHIFT) && advance) begin
      if (!ser_last) begin
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
      end else begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      sh_a_d  = in_a;
      sh_b_d  = in_b;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

endmodule

// File: tb/tb_operand_pair_serializer.sv
// Self-checking bench for operand_pair_serializer: WIDTH=4 and WIDTH=1 instances against a word/bit-index model.
module tb_operand_pair_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_vld = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         ser_rdy = 1'b1;
  logic         in_rdy, ser_vld, ser_a, ser_b, ser_last, busy;

  logic         in_vld1 = 1'b0;
  logic [0:0]   in_a1 = '0, in_b1 = '0;
  logic         in_rdy1, ser_vld1, ser_a1, ser_b1, ser_last1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_pair_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last),
`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
    .ser_rdy(ser_rdy),
`endif
    .busy(busy)
  );

  operand_pair_serializer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(in_rdy1), .in_a(in_a1), .in_b(in_b1),
    .ser_vld(ser_vld1), .ser_a(ser_a1), .ser_b(ser_b1), .ser_last(ser_last1),
`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
    .ser_rdy(1'b1),
`endif
    .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic adv_now();
`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
    return ser_rdy;
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: a word in flight plus the index of the bit currently on the wire.
  logic         armed = 1'b0;
  logic         m_busy = 1'b0, m_rst = 1'b0;
  int           m_idx = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m1_busy = 1'b0;
  logic         m1_a = 1'b0, m1_b = 1'b0;

  always @(posedge clk) begin
    logic nb, rdy, n1b;
    int   ni;
    armed <= 1'b1;
    if (rst) begin
      m_busy  <= 1'b0;
      m_rst   <= 1'b1;
      m1_busy <= 1'b0;
    end else begin
      m_rst <= 1'b0;
      nb  = m_busy;
      ni  = m_idx;
      rdy = !m_busy || (m_idx == W-1 && adv_now());
      if (m_busy && adv_now()) begin
        if (m_idx == W-1) nb = 1'b0;
        else ni = m_idx + 1;
      end
      if (in_vld && rdy) begin
        nb = 1'b1;
        ni = 0;
        m_a <= in_a;
        m_b <= in_b;
      end
      m_busy <= nb;
      m_idx  <= ni;
      // Single-bit words: every accepted pair is shown for exactly one cycle.
      n1b = in_vld1;
      if (in_vld1) begin
        m1_a <= in_a1[0];
        m1_b <= in_b1[0];
      end
      m1_busy <= n1b;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("ser_vld", ser_vld, m_busy);
      check("busy", busy, m_busy);
      check("ser_last", ser_last, m_busy && (m_idx == W-1));
      check("in_rdy", in_rdy, !m_busy || (m_idx == W-1 && adv_now()));
      if (m_busy) begin
        check("ser_a", ser_a, m_a[m_idx]);
        check("ser_b", ser_b, m_b[m_idx]);
      end
      if (m_rst) begin
        check("rst_ser_a", ser_a, 1'b0);
        check("rst_ser_b", ser_b, 1'b0);
      end
      check("w1_ser_vld", ser_vld1, m1_busy);
      check("w1_ser_last", ser_last1, m1_busy);
      check("w1_in_rdy", in_rdy1, 1'b1);
      if (m1_busy) begin
        check("w1_ser_a", ser_a1, m1_a);
        check("w1_ser_b", ser_b1, m1_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 0;
    in_vld = 1'b1;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      done = in_rdy;
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_rdy stayed 0, expected 1 within 50 cycles");
    end
    in_vld = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ga, gb, gl, sum;
    logic [8:0]   vseq;
    logic         c;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_in_rdy", in_rdy, 1'b1);
    check("reset_ser_vld", ser_vld, 1'b0);

    // Directed word 1011/0110, then a bit-serial add of what came out.
    send(4'b1011, 4'b0110);
    for (int i = 0; i < W; i++) begin
      #1;
      ga[i] = ser_a;
      gb[i] = ser_b;
      gl[i] = ser_last;
      tick();
    end
    #1;
    check("t1_a_bits", ga, 4'b1011);
    check("t1_b_bits", gb, 4'b0110);
    check("t1_last_pos", gl, 4'b1000);
    check("t1_vld_after", ser_vld, 1'b0);
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      sum[i] = ga[i] ^ gb[i] ^ c;
      c = (ga[i] & gb[i]) | (c & (ga[i] ^ gb[i]));
    end
    check("t1_sum", sum, 4'b0001);
    tick();

    // Back-to-back: (3,5) then (15,1) with no gap.
    fork
      begin
        send(4'd3, 4'd5);
        send(4'd15, 4'd1);
      end
      begin
        tick();
        for (int k = 0; k < 9; k++) begin
          #1;
          vseq[k] = ser_vld;
          if (k >= 4 && k < 8) begin
            ga[k-4] = ser_a;
            gb[k-4] = ser_b;
          end
          tick();
        end
      end
    join
    check("t2_vld_run", vseq, 9'h0FF);
    check("t2_word2_a", ga, 4'b1111);
    check("t2_word2_b", gb, 4'b0001);

    // Busy rejection.
    send(4'hA, 4'h5);
    in_vld = 1'b1;
    in_a = 4'h3;
    in_b = 4'hC;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_rdy_low", in_rdy, 1'b0);
      tick();
    end
    #1;
    check("t3_rdy_last", in_rdy, 1'b1);
    tick();
    in_vld = 1'b0;
    repeat (W) tick();

    // Reset mid-word while the third bit is on the wire.
    send(4'h9, 4'h6);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t4_vld", ser_vld, 1'b0);
    check("t4_last", ser_last, 1'b0);
    check("t4_rdy", in_rdy, 1'b1);
    send(4'h6, 4'h9);
    repeat (W + 1) tick();

    // WIDTH=1 streaming.
    in_vld1 = 1'b1;
    in_a1 = 1'b1;
    in_b1 = 1'b1;
    tick();
    in_a1 = 1'b0;
    #1;
    check("t5_a0", ser_a1, 1'b1);
    check("t5_last0", ser_last1, 1'b1);
    tick();
    in_vld1 = 1'b0;
    #1;
    check("t5_a1", ser_a1, 1'b0);
    check("t5_b1", ser_b1, 1'b1);
    check("t5_last1", ser_last1, 1'b1);
    tick();
    #1;
    check("t5_vld_end", ser_vld1, 1'b0);

`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
    // Stall during bit 1.
    send(4'b0110, 4'b1001);
    tick();
    ser_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t6_a_hold", ser_a, 1'b1);
      check("t6_b_hold", ser_b, 1'b0);
      check("t6_last_hold", ser_last, 1'b0);
      tick();
    end
    ser_rdy = 1'b1;
    repeat (2) tick();
    ser_rdy = 1'b0;
    #1;
    check("t6_last_seen", ser_last, 1'b1);
    check("t6_rdy_stalled", in_rdy, 1'b0);
    tick();
    ser_rdy = 1'b1;
    repeat (2) tick();
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      in_vld  = $urandom_range(0, 2) != 0;
      in_a    = W'($urandom);
      in_b    = W'($urandom);
`ifdef OPERAND_PAIR_SERIALIZER_STALL_EN
      ser_rdy = $urandom_range(0, 3) != 0;
`endif
      in_vld1 = $urandom_range(0, 1) != 0;
      in_a1   = 1'($urandom);
      in_b1   = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    in_vld = 1'b0;
    in_vld1 = 1'b0;
    ser_rdy = 1'b1;
    repeat (2 * W + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_pair_serializer.md
Name: operand_pair_serializer

Overview:
Upstream feeder for the bit-serial adder. Accepts a pair of WIDTH-bit operands over a valid/ready handshake and emits them LSB-first, one bit pair per cycle. Each bit pair is qualified by ser_vld, and ser_last marks the MSB. Output timing allows back-to-back words with no bubble between them, so the serial adder's carry clears exactly at word boundaries.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_vld  input  1  parallel operand pair valid
in_rdy  output  1  block can accept a pair this cycle
in_a  input  WIDTH  operand A, captured on in_vld && in_rdy
in_b  input  WIDTH  operand B, captured on in_vld && in_rdy
ser_vld  output  1  ser_a/ser_b/ser_last valid this cycle
ser_a  output  1  current bit of A, LSB first
ser_b  output  1  current bit of B, LSB first
ser_last  output  1  current bit is the MSB (bit WIDTH-1); asserted only with ser_vld
busy  output  1  word in flight; equals ser_vld

Behaviour:
- State:
  - FSM with states IDLE and SHIFT.
  - Shift registers sh_a and sh_b, WIDTH bits each.
  - Bit counter cnt, $clog2(WIDTH) bits, minimum 1 bit.
- advance = 1 without the optional feature (see below).
- ser_vld = (state == SHIFT).
- ser_a = sh_a[0]; ser_b = sh_b[0].
- ser_last = SHIFT && cnt == WIDTH-1.
- in_rdy = IDLE || (ser_last && advance). in_rdy is combinational from registered state only; it never depends on in_vld.
- Accept event: accept = in_vld && in_rdy. On accept:
  - Load sh_a <= in_a and sh_b <= in_b.
  - Set cnt <= 0 and state <= SHIFT.
- Latency: bit 0 appears on ser_a/ser_b in the cycle after accept.
- In SHIFT with advance and not ser_last:
  - sh_a and sh_b shift right by 1; fill value is don't-care, drive 0.
  - cnt <= cnt + 1.
- In SHIFT with advance and ser_last:
  - If accept, load the new pair (back-to-back case). The next cycle shows bit 0 of the new word with ser_vld=1 and no gap.
  - Otherwise, state <= IDLE.
- Throughput: one pair per WIDTH cycles when in_vld is held high.
- WIDTH == 1: every ser_vld cycle also has ser_last=1, and in_rdy=1 in every cycle while advance holds.
- in_vld asserted while busy and not on the last bit: not accepted. in_rdy=0, and the upstream holds in_a/in_b stable.
- in_a/in_b changing after accept has no effect on the word in flight.
- Reset (any cycle, including mid-word):
  - state <= IDLE and cnt <= 0.
  - sh_a and sh_b <= 0.
  - The in-flight word is dropped; no ser_last is emitted for it.
  - Outputs in the cycle after rst: ser_vld=0, ser_a=0, ser_b=0, ser_last=0, busy=0, in_rdy=1.
- rst has priority over accept in the same cycle; the pair is not captured.
- No output glitches: ser_* are driven from flops plus equality decode only.

Optional Feature:
Macro OPERAND_PAIR_SERIALIZER_STALL_EN.
- Defined:
  - Adds input port ser_rdy (1 bit, after ser_last), and advance = ser_rdy.
  - While ser_vld && !ser_rdy, ser_a, ser_b, ser_last, cnt and the shift registers hold stable, and in_rdy follows the formula above, so it stays 0 on the last bit.
  - A bit is consumed only on ser_vld && ser_rdy; the downstream must qualify its vld with ser_rdy.
  - ser_rdy is ignored in IDLE.
- Not defined: the port is absent, advance = 1, and the downstream is assumed always ready.

Test Plan:
1. WIDTH=4, in_a=4'b1011, in_b=4'b0110 accepted at cycle 0. Required response:
   - Cycles 1-4: ser_a=1,1,0,1 and ser_b=0,1,1,0.
   - ser_last=1 only at cycle 4; ser_vld=0 at cycle 5.
   - Chained into the serial adder, the sum bits read 1,0,0,0 (= 17 mod 16).
2. Back-to-back, WIDTH=4: in_vld held with pairs (3,5) then (15,1). Required response:
   - in_rdy=1 at cycles 0 and 4.
   - ser_vld stays high for cycles 1-8 with no gap.
   - ser_last at cycles 4 and 8; the second word reads a=1,1,1,1 and b=1,0,0,0.
3. Busy rejection: pair accepted at cycle 0, then in_vld=1 with new data at cycles 1-3. Required response:
   - in_rdy=0 at cycles 1-3.
   - Original bits are unchanged; the new pair is accepted at cycle 4.
4. Reset mid-word: WIDTH=8, rst pulsed at the 3rd serial bit. Required response:
   - Next cycle: ser_vld=0, ser_last never seen, in_rdy=1.
   - The following accept restarts at bit 0.
5. WIDTH=1: pairs (1,1) and (0,1) streamed. Required response:
   - ser_last=1 on every ser_vld cycle.
   - One pair accepted per cycle.
6. STALL_EN defined, WIDTH=4: ser_rdy=0 during bit 1 for 3 cycles. Required response:
   - ser_a, ser_b and ser_last hold stable.
   - ser_last appears only after 4 handshakes, and in_rdy stays 0 while the last bit is stalled.
